fu_alu_pipe: RTL

FU_ALU_PIPE -- requirements
Module: fu_alu_pipe

---
 rtl/rv32i_types.sv | 81 ++++++++
 rtl/fu_alu_core.sv | 67 ++++++
 rtl/fu_alu_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I decode types, ALU operation encodings and the result-pipeline stage record.
package rv32i_types;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    arith_f3_add  = 3'b000,
    arith_f3_sll  = 3'b001,
    arith_f3_slt  = 3'b010,
    arith_f3_sltu = 3'b011,
    arith_f3_xor  = 3'b100,
    arith_f3_sr   = 3'b101,
    arith_f3_or   = 3'b110,
    arith_f3_and  = 3'b111
  } arith_f3_t;

  typedef enum logic [2:0] {
    branch_f3_beq  = 3'b000,
    branch_f3_bne  = 3'b001,
    branch_f3_blt  = 3'b100,
    branch_f3_bge  = 3'b101,
    branch_f3_bltu = 3'b110,
    branch_f3_bgeu = 3'b111
  } branch_f3_t;

  typedef enum logic [2:0] {
    alu_op_add = 3'b000,
    alu_op_sll = 3'b001,
    alu_op_sra = 3'b010,
    alu_op_sub = 3'b011,
    alu_op_xor = 3'b100,
    alu_op_srl = 3'b101,
    alu_op_or  = 3'b110,
    alu_op_and = 3'b111
  } alu_ops;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
  } decode_info_t;

  // Tag fields are sized for the widest supported tag; users keep the low bits.
  localparam int unsigned TAG_BITS_MAX = 16;

  typedef struct packed {
    logic [31:0]             rd_v;
    logic [TAG_BITS_MAX-1:0] pd;
    logic [TAG_BITS_MAX-1:0] rob_idx;
    logic                    br_en;
  } alu_stage_t;

  function automatic logic [31:0] alu_eval(alu_ops op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      alu_op_add: r = a + b;
      alu_op_sub: r = a - b;
      alu_op_sll: r = a << b[4:0];
      alu_op_srl: r = a >> b[4:0];
      alu_op_sra: r = $unsigned($signed(a) >>> b[4:0]);
      alu_op_xor: r = a ^ b;
      alu_op_or:  r = a | b;
      alu_op_and: r = a & b;
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fu_alu_core.sv
// Combinational RV32I integer datapath for the ALU functional unit.
// Branch compare evaluation is present only with FU_ALU_BRANCH_CMP_EN defined.
module fu_alu_core
  import rv32i_types::*;
(
  input  logic [31:0]  rs1_v,
  input  logic [31:0]  rs2_v,
  input  decode_info_t decode_info,
  output logic [31:0]  rd_v,
  output logic         br_en
);

  logic [31:0] opb;
  logic        use_alu;
  alu_ops      op;
  arith_f3_t   f3;
  logic        alt;

  assign f3  = arith_f3_t'(decode_info.funct3);
  assign alt = decode_info.funct7[5];

  // Only funct7[5] distinguishes sub/sra; the other bits are don't-care.
  logic unused_f7;
  assign unused_f7 = ^{decode_info.funct7[6], decode_info.funct7[4:0]};

  always_comb begin
    opb     = (decode_info.opcode == op_b_reg) ? rs2_v : decode_info.i_imm;
    rd_v    = '0;
    br_en   = 1'b0;
    use_alu = 1'b0;
    op      = alu_op_add;
    case (decode_info.opcode)
      op_b_imm, op_b_reg: begin
        case (f3)
          arith_f3_add: begin
            use_alu = 1'b1;
            op      = (decode_info.opcode == op_b_reg && alt) ? alu_op_sub : alu_op_add;
          end
          arith_f3_sll:  begin use_alu = 1'b1; op = alu_op_sll; end
          arith_f3_slt:  rd_v = {31'b0, $signed(rs1_v) < $signed(opb)};
          arith_f3_sltu: rd_v = {31'b0, rs1_v < opb};
          arith_f3_xor:  begin use_alu = 1'b1; op = alu_op_xor; end
          arith_f3_sr:   begin use_alu = 1'b1; op = alt ? alu_op_sra : alu_op_srl; end
          arith_f3_or:   begin use_alu = 1'b1; op = alu_op_or; end
          arith_f3_and:  begin use_alu = 1'b1; op = alu_op_and; end
          default:       rd_v = '0;
        endcase
      end
`ifdef FU_ALU_BRANCH_CMP_EN
      op_b_br: begin
        case (branch_f3_t'(decode_info.funct3))
          branch_f3_beq:  br_en = (rs1_v == rs2_v);
          branch_f3_bne:  br_en = (rs1_v != rs2_v);
          branch_f3_blt:  br_en = ($signed(rs1_v) <  $signed(rs2_v));
          branch_f3_bge:  br_en = ($signed(rs1_v) >= $signed(rs2_v));
          branch_f3_bltu: br_en = (rs1_v <  rs2_v);
          branch_f3_bgeu: br_en = (rs1_v >= rs2_v);
          default:        br_en = 1'b0;
        endcase
      end
`endif
      default: rd_v = '0;
    endcase
    if (use_alu) rd_v = alu_eval(op, rs1_v, opb);
  end

endmodule

// File: rtl/fu_alu_pipe.sv
// ALU functional unit: issue handshake plus STAGES-deep elastic result pipeline to the CDB.
// Define FU_ALU_BRANCH_CMP_EN to add the br_en output and branch compare support.
module fu_alu_pipe
  import rv32i_types::*;
#(
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned ROB_IDX_BITS  = 5,
  parameter int unsigned STAGES        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              rs1_v,
  input  logic [31:0]              rs2_v,
  input  decode_info_t             decode_info,
  input  logic [PHYS_REG_BITS-1:0] pd_in,
  input  logic [ROB_IDX_BITS-1:0]  rob_idx_in,
  input  logic                     flush,
  input  logic                     cdb_grant,
  output logic                     busy,
  output logic                     valid,
  output logic [31:0]              rd_v,
  output logic [PHYS_REG_BITS-1:0] pd_out,
  output logic [ROB_IDX_BITS-1:0]  rob_idx_out
`ifdef FU_ALU_BRANCH_CMP_EN
  ,
  output logic                     br_en
`endif
);

  localparam int unsigned LAST = STAGES - 1;

  alu_stage_t        stage_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] leaves;
  logic [STAGES-1:0] can_take;
  alu_stage_t        issue_rec;
  logic [31:0]       core_rd;
  logic              core_br;
  logic              accept;

  fu_alu_core u_core (
    .rs1_v       (rs1_v),
    .rs2_v       (rs2_v),
    .decode_info (decode_info),
    .rd_v        (core_rd),
    .br_en       (core_br)
  );

  always_comb begin
    issue_rec         = '0;
    issue_rec.rd_v    = core_rd;
    issue_rec.pd      = TAG_BITS_MAX'(pd_in);
    issue_rec.rob_idx = TAG_BITS_MAX'(rob_idx_in);
    issue_rec.br_en   = core_br;
  end

  // Readiness ripples back from the output: a stage can take new data when it
  // is empty or its own content is leaving this edge.
  always_comb begin
    leaves         = '0;
    can_take       = '0;
    leaves[LAST]   = cdb_grant;
    can_take[LAST] = !valid_q[LAST] || cdb_grant;
    for (int unsigned i = LAST; i > 0; i--) begin
      leaves[i-1]   = can_take[i];
      can_take[i-1] = !valid_q[i-1] || leaves[i-1];
    end
  end

  assign busy   = valid_q[0] && !leaves[0];
  assign accept = start && !busy && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (can_take[0]) begin
        valid_q[0] <= accept;
        stage_q[0] <= issue_rec;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (can_take[i]) begin
          valid_q[i] <= valid_q[i-1];
          stage_q[i] <= stage_q[i-1];
        end
      end
    end
  end

  // Upper tag bits are always zero; fold them away.
  logic unused_stage_bits;
  assign unused_stage_bits = ^stage_q[LAST];

  always_comb begin
    valid       = valid_q[LAST];
    rd_v        = valid ? stage_q[LAST].rd_v : '0;
    pd_out      = valid ? stage_q[LAST].pd[PHYS_REG_BITS-1:0] : '0;
    rob_idx_out = valid ? stage_q[LAST].rob_idx[ROB_IDX_BITS-1:0] : '0;
`ifdef FU_ALU_BRANCH_CMP_EN
    br_en       = valid ? stage_q[LAST].br_en : 1'b0;
`endif
  end

endmodule
